// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues aligned line requests,
// splits returned lines from the PC's slot onward and buffers them in a circular queue.
module fetch_queue_unit #(
  parameter int ADDR_LEN    = 32,
  parameter int INSN_LEN    = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QDEPTH      = 8,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  output logic                            imem_req_o,
  output logic [ADDR_LEN-1:0]             imem_addr_o,
  input  logic                            imem_valid_i,
  input  logic [FETCH_WIDTH*INSN_LEN-1:0] imem_rdata_i,
  input  logic                            redirect_i,
  input  logic [ADDR_LEN-1:0]             redirect_pc_i,
  output logic                            inst_valid_o,
  output logic [INSN_LEN-1:0]             inst_o,
  output logic [ADDR_LEN-1:0]             inst_pc_o,
  input  logic                            inst_ready_i,
  output logic [$clog2(QDEPTH):0]         count_o
);

  localparam int LFW = $clog2(FETCH_WIDTH);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = QAW + 1;

  logic [ADDR_LEN-1:0] fpc;
  logic [QAW-1:0]      head, tail;
  logic [CW-1:0]       count;
  logic                outstanding, squash;
  logic [LFW-1:0]      req_off;

  logic [INSN_LEN-1:0] mem_inst [QDEPTH];
  logic [ADDR_LEN-1:0] mem_pc   [QDEPTH];

  logic [LFW-1:0]      off;
  logic [CW-1:0]       needed, free, n_push;
  logic [ADDR_LEN-1:0] line_base;
  logic                resp, push, pop;
  logic [QAW-1:0]      wr_idx [FETCH_WIDTH];
  logic                unused_pc_bits;

  // Word-aligned PCs: the two byte-offset bits never carry information.
  assign unused_pc_bits = ^{redirect_pc_i[1:0], fpc[1:0]};

  assign off       = fpc[LFW+1:2];
  assign needed    = CW'(FETCH_WIDTH) - CW'(off);
  assign free      = CW'(QDEPTH) - count;
  assign n_push    = CW'(FETCH_WIDTH) - CW'(req_off);
  assign line_base = {fpc[ADDR_LEN-1:LFW+2], {(LFW+2){1'b0}}};

  assign resp = imem_valid_i && outstanding;
  assign push = resp && !squash && !redirect_i;
  assign pop  = inst_valid_o && inst_ready_i && !redirect_i;

  assign imem_req_o   = reset_i && !outstanding && (free >= needed) && !redirect_i;
  assign imem_addr_o  = line_base;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? mem_inst[head] : '0;
  assign inst_pc_o    = inst_valid_o ? mem_pc[head]   : '0;
  assign count_o      = count;

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_idx[k] = tail + QAW'(k) - QAW'(req_off);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fpc         <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      req_off     <= '0;
    end else if (redirect_i) begin
      fpc   <= redirect_pc_i & ~ADDR_LEN'(3);
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // A response landing this cycle is simply dropped; otherwise mark the next one stale.
      if (resp) begin
        outstanding <= 1'b0;
        squash      <= 1'b0;
      end else if (outstanding) begin
        squash <= 1'b1;
      end
    end else begin
      if (resp) begin
        outstanding <= 1'b0;
        squash      <= 1'b0;
        if (!squash) fpc <= line_base + ADDR_LEN'(4 * FETCH_WIDTH);
      end else if (imem_req_o) begin
        outstanding <= 1'b1;
        req_off     <= off;
      end
      if (push) tail <= tail + QAW'(n_push);
      if (pop)  head <= head + 1'b1;
      count <= count + (push ? n_push : CW'(0)) - CW'(pop);
    end
  end

  // Queue storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (k >= int'(req_off)) begin
          mem_inst[wr_idx[k]] <= imem_rdata_i[k*INSN_LEN +: INSN_LEN];
          mem_pc[wr_idx[k]]   <= line_base + ADDR_LEN'(4 * k);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-based reference model
// with a memory responder of random latency.
module tb_fetch_queue_unit;

  localparam int AL = 32;
  localparam int IL = 32;
  localparam int FW = 2;
  localparam int QD = 8;
  localparam logic [31:0] RPC = 32'h100;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              imem_req_o;
  logic [AL-1:0]     imem_addr_o;
  logic              imem_valid_i = 1'b0;
  logic [FW*IL-1:0]  imem_rdata_i = '0;
  logic              redirect_i = 1'b0;
  logic [AL-1:0]     redirect_pc_i = '0;
  logic              inst_valid_o;
  logic [IL-1:0]     inst_o;
  logic [AL-1:0]     inst_pc_o;
  logic              inst_ready_i = 1'b0;
  logic [3:0]        count_o;

  fetch_queue_unit #(.ADDR_LEN(AL), .INSN_LEN(IL), .FETCH_WIDTH(FW), .QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_fpc;
  bit          m_out, m_sq;
  int          m_off, m_delay;

  task automatic model_reset();
    q_inst.delete();
    q_pc.delete();
    m_fpc = RPC;
    m_out = 0;
    m_sq  = 0;
    m_off = 0;
    m_delay = 0;
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req",   imem_req_o,   0);
    check_val("rst_valid", inst_valid_o, 0);
    check_val("rst_count", count_o,      0);
    check_val("rst_inst",  inst_o,       0);
    check_val("rst_pc",    inst_pc_o,    0);
  endtask

  initial begin
    bit   resp, exp_req, pop, late;
    int   ready_pct, redir_pct, sel;
    logic [31:0] base;

    model_reset();
    late = 0;
    #3 check_reset_outputs();
    @(negedge clk_i);
    reset_i = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc != 0) @(negedge clk_i);

      if (cyc == 1500) begin
        // Asynchronous reset mid-stream, then a stray response after release.
        #2 reset_i = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        late = 1;
      end

      if (cyc < 400)       begin ready_pct = 70; redir_pct = 3;  end
      else if (cyc <= 520) begin ready_pct = 0;  redir_pct = 0;  end
      else if (cyc < 1000) begin ready_pct = 90; redir_pct = 0;  end
      else if (cyc < 1500) begin ready_pct = 50; redir_pct = 10; end
      else                 begin ready_pct = 60; redir_pct = 4;  end

      redirect_i = (cyc == 400) || ($urandom_range(0, 99) < redir_pct);
      sel = $urandom_range(0, 9);
      if (cyc == 400)    redirect_pc_i = 32'h300;
      else if (sel == 0) redirect_pc_i = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else               redirect_pc_i = 32'h200 + $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
      inst_ready_i = ($urandom_range(0, 99) < ready_pct);
      for (int k = 0; k < FW; k++) imem_rdata_i[k*IL +: IL] = $urandom;
      resp = m_out && (m_delay == 0);
      imem_valid_i = resp || late;

      #1;
      exp_req = !m_out && ((QD - q_inst.size()) >= (FW - int'(m_fpc[2]))) && !redirect_i;
      check_val("req", imem_req_o, exp_req);
      if (exp_req) check_val("addr", imem_addr_o, m_fpc & ~32'h7);
      if (late) begin
        check_val("post_rst_addr", imem_addr_o, RPC);
        late = 0;
      end
      check_val("count", count_o, q_inst.size());
      check_val("valid", inst_valid_o, q_inst.size() != 0);
      if (q_inst.size() != 0) begin
        check_val("inst", inst_o, q_inst[0]);
        check_val("inst_pc", inst_pc_o, q_pc[0]);
      end
      if (cyc == 520) check_val("fill_count", count_o, QD);

      @(posedge clk_i);
      pop = (q_inst.size() != 0) && inst_ready_i;
      if (redirect_i) begin
        q_inst.delete();
        q_pc.delete();
        if (resp) begin m_out = 0; m_sq = 0; end
        else if (m_out) m_sq = 1;
        m_fpc = redirect_pc_i & ~32'h3;
      end else begin
        if (pop) begin
          void'(q_inst.pop_front());
          void'(q_pc.pop_front());
        end
        if (resp) begin
          m_out = 0;
          if (m_sq) m_sq = 0;
          else begin
            base = m_fpc & ~32'h7;
            for (int k = m_off; k < FW; k++) begin
              q_inst.push_back(imem_rdata_i[k*IL +: IL]);
              q_pc.push_back(base + 4 * k);
            end
            m_fpc = base + 4 * FW;
          end
        end else if (exp_req) begin
          m_out = 1;
          m_off = int'(m_fpc[2]);
          m_delay = $urandom_range(0, 3);
        end
      end
      if (m_out && !resp && m_delay > 0 && !(exp_req && !redirect_i)) m_delay--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
